// File: rtl/anim_seq_counter.sv
// Animation/frame sequencer: a prescaler with speed select drives a modulo-FRAMES frame counter.
// Optional ping-pong ordering is enabled with the ANIM_PINGPONG_EN macro.
module anim_seq_counter #(
   parameter int CLK_DIV = 5000000,
   parameter int PW      = 26,
   parameter int FRAMES  = 6,
   parameter int FW      = 3
) (
   input  logic          C,
   input  logic          R,
   input  logic          en,
   input  logic [1:0]    speed,
   input  logic          load,
   input  logic [FW-1:0] load_val,
   output logic [FW-1:0] frame,
   output logic          tick,
   output logic          wrap
);

   localparam logic [PW-1:0] DIV_BASE = PW'(CLK_DIV);
   localparam logic [FW-1:0] LAST     = FW'(FRAMES - 1);
`ifdef ANIM_PINGPONG_EN
   localparam logic [FW-1:0] PENULT   = FW'(FRAMES - 2);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   dir_t dir, dir_nxt;
`endif

   logic [PW-1:0] presc, presc_nxt;
   logic [PW-1:0] div_sel, lim;
   logic [FW-1:0] frame_nxt;
   logic          tick_nxt, wrap_nxt, tick_ev;

   function automatic logic [FW-1:0] clamp_load(input logic [FW-1:0] v);
      return (v > LAST) ? LAST : v;
   endfunction

   // A shifted divider of zero still means a tick every cycle.
   always_comb begin
      div_sel = DIV_BASE >> speed;
      lim     = (div_sel == '0) ? '0 : div_sel - PW'(1);
   end

   // Using >= lets a speed increase past the current count fire immediately.
   assign tick_ev = en && (presc >= lim);

   always_comb begin
      presc_nxt = presc;
      frame_nxt = frame;
      tick_nxt  = 1'b0;
      wrap_nxt  = 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_nxt   = dir;
`endif
      if (load) begin
         frame_nxt = clamp_load(load_val);
         presc_nxt = '0;
`ifdef ANIM_PINGPONG_EN
         dir_nxt   = DIR_UP;
`endif
      end else if (en) begin
         if (tick_ev) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
`ifdef ANIM_PINGPONG_EN
            if (dir == DIR_UP) begin
               if (frame == LAST) begin
                  dir_nxt   = DIR_DOWN;
                  frame_nxt = PENULT;
               end else begin
                  frame_nxt = frame + FW'(1);
               end
            end else begin
               if (frame == '0) begin
                  dir_nxt   = DIR_UP;
                  frame_nxt = FW'(1);
                  wrap_nxt  = 1'b1;
               end else begin
                  frame_nxt = frame - FW'(1);
               end
            end
`else
            if (frame == LAST) begin
               frame_nxt = '0;
               wrap_nxt  = 1'b1;
            end else begin
               frame_nxt = frame + FW'(1);
            end
`endif
         end else begin
            presc_nxt = presc + PW'(1);
         end
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         presc <= '0;
         frame <= '0;
         tick  <= 1'b0;
         wrap  <= 1'b0;
`ifdef ANIM_PINGPONG_EN
         dir   <= DIR_UP;
`endif
      end else begin
         presc <= presc_nxt;
         frame <= frame_nxt;
         tick  <= tick_nxt;
         wrap  <= wrap_nxt;
`ifdef ANIM_PINGPONG_EN
         dir   <= dir_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_anim_seq_counter.sv
// Directed bench for anim_seq_counter with CLK_DIV=4, FRAMES=6, FW=3, PW=4.
// Expected frames follow the ordering selected by ANIM_PINGPONG_EN.
module tb_anim_seq_counter;

   logic       C = 1'b0;
   logic       R, en, load;
   logic [1:0] speed;
   logic [2:0] load_val;
   logic [2:0] frame;
   logic       tick, wrap;

   int n_cmp = 0;
   int n_err = 0;
   int ef    = 0;   // expected frame
   int ed    = 0;   // expected direction, 0 = up
   int ew    = 0;   // expected wrap

   anim_seq_counter #(.CLK_DIV(4), .PW(4), .FRAMES(6), .FW(3)) dut (
      .C(C), .R(R), .en(en), .speed(speed), .load(load), .load_val(load_val),
      .frame(frame), .tick(tick), .wrap(wrap)
   );

   always #5 C = ~C;

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_tick();
      ew = 0;
`ifdef ANIM_PINGPONG_EN
      if (ed == 0) begin
         if (ef == 5) begin ed = 1; ef = 4; end
         else ef = ef + 1;
      end else begin
         if (ef == 0) begin ed = 0; ef = 1; ew = 1; end
         else ef = ef - 1;
      end
`else
      if (ef == 5) begin ef = 0; ew = 1; end
      else ef = ef + 1;
`endif
   endtask

   // One clock; tk says whether a tick is expected on this edge.
   task automatic cyc(input bit tk, input string tag);
      @(posedge C); #1;
      if (tk) model_tick();
      else ew = 0;
      chk({tag, "_tick"}, int'(tick), int'(tk));
      chk({tag, "_wrap"}, int'(wrap), ew);
      chk({tag, "_frame"}, int'(frame), ef);
   endtask

   task automatic cyc_load(input int v, input int exp_frame, input string tag);
      load = 1'b1; load_val = 3'(v);
      @(posedge C); #1;
      load = 1'b0;
      ef = exp_frame; ed = 0; ew = 0;
      chk({tag, "_tick"}, int'(tick), 0);
      chk({tag, "_wrap"}, int'(wrap), 0);
      chk({tag, "_frame"}, int'(frame), exp_frame);
   endtask

   initial begin
      R = 1'b1; en = 1'b0; load = 1'b0; speed = 2'd0; load_val = 3'd0;
      cyc(1'b0, "reset");
      R = 1'b0; en = 1'b1;

      // Base period: tick every 4 cycles through a full sequence and beyond
      for (int f = 0; f < 12; f++)
         for (int k = 0; k < 4; k++) cyc(k == 3, "run4");

      // lim = 0: tick every cycle
      speed = 2'd2;
      for (int k = 0; k < 3; k++) cyc(1'b1, "fast");

      // Count to presc=3 at speed 0, then switch to speed 1
      speed = 2'd0;
      for (int k = 0; k < 3; k++) cyc(1'b0, "pre_sw");
      speed = 2'd1;
      cyc(1'b1, "sw_now");
      for (int k = 0; k < 6; k++) cyc(k % 2 == 1, "run2");

      // Clamped load, then presc restarts from zero
      speed = 2'd0;
      cyc(1'b0, "pre_ld0");
      cyc(1'b0, "pre_ld1");
      cyc_load(7, 5, "ld_clamp");
      for (int k = 0; k < 4; k++) cyc(k == 3, "after_ld");

      // Load on the same edge as a pending tick
      for (int k = 0; k < 3; k++) cyc(1'b0, "pend");
      cyc_load(2, 2, "ld_win");
      for (int k = 0; k < 4; k++) cyc(k == 3, "after_win");

      // Freeze mid-count with presc=2, then resume with the remaining count
      cyc(1'b0, "pre_frz0");
      cyc(1'b0, "pre_frz1");
      en = 1'b0;
      for (int k = 0; k < 10; k++) cyc(1'b0, "frozen");
      en = 1'b1;
      cyc(1'b0, "resume0");
      cyc(1'b1, "resume1");

      // Load acts while disabled
      en = 1'b0;
      cyc_load(1, 1, "ld_en0");
      en = 1'b1;

      // Reset mid-sequence with presc=3 pending
      for (int k = 0; k < 3; k++) cyc(1'b0, "pre_rst");
      R = 1'b1;
      @(posedge C); #1;
      ef = 0; ed = 0; ew = 0;
      chk("rst_mid_frame", int'(frame), 0);
      chk("rst_mid_tick", int'(tick), 0);
      chk("rst_mid_wrap", int'(wrap), 0);
      R = 1'b0;

      // Load after six fast ticks, then the next tick must count up from the loaded value
      speed = 2'd2;
      for (int k = 0; k < 6; k++) cyc(1'b1, "pp_fast");
      cyc_load(3, 3, "ld_dirup");
      cyc(1'b1, "dir_up");
      chk("dir_up_val", int'(frame), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
